// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice is reused
// for NIB cycles, LSB nibble first, with the slice carry registered between
// nibbles. Results are registered and only change on completion.

// 4-bit carry-lookahead slice with group propagate
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       p_grp
);
    logic [3:0] g, p, c;

    // Lookahead carries computed directly from generate/propagate terms
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c[0]  = ci;
        c[1]  = g[0] | (p[0] & ci);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
        s     = p ^ c;
        p_grp = &p;
    end
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             prop_all
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    // sum_sh only needs to hold the NIB-1 nibbles finished before the last one
    localparam int SW  = (WIDTH > 4) ? WIDTH - 4 : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [SW-1:0]    sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry_reg;
    logic             prop_acc;
    logic             a_msb, b_msb;

    logic [3:0]       slice_s;
    logic             slice_co;
    logic             slice_p;
    logic [WIDTH-1:0] sum_nxt;
    logic             last;

    cla4 u_slice (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .ci    (carry_reg),
        .s     (slice_s),
        .co    (slice_co),
        .p_grp (slice_p)
    );

    // Word result with the current slice nibble placed on top
    generate
        if (WIDTH > 4) begin : g_wide
            assign sum_nxt = {slice_s, sum_sh};
        end else begin : g_narrow
            assign sum_nxt = slice_s;
        end
    endgenerate

    assign last = (cnt == CW'(NIB - 1));
    assign busy = (state == RUN);

    // Control, datapath shift registers and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
            prop_acc  <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            prop_all  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= cin;
                        a_msb     <= a[WIDTH-1];
                        b_msb     <= b[WIDTH-1];
                        cnt       <= '0;
                        prop_acc  <= 1'b1;
                        state     <= RUN;
                    end
                end
                default: begin
                    a_sh      <= a_sh >> 4;
                    b_sh      <= b_sh >> 4;
                    sum_sh    <= sum_nxt[WIDTH-1:WIDTH-SW];
                    carry_reg <= slice_co;
                    prop_acc  <= prop_acc & slice_p;
                    cnt       <= cnt + CW'(1);
                    if (last) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        sum      <= sum_nxt;
                        cout     <= slice_co;
                        prop_all <= prop_acc & slice_p;
                        ovf      <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Bench for cla_nibble_serial_adder at WIDTH=32: directed table, random
// operands against an arithmetic model, and multi-cycle corner sequences.
module tb_cla_nibble_serial_adder;
    localparam int W   = 32;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf, prop_all;
    logic [W-1:0] sum;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt;
    bit timed_out;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .prop_all(prop_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] s;
        logic         co, ov, pa;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition and the signed-overflow rule
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic mov,
                         output logic mpa);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ms   = full[W-1:0];
        mco  = full[W];
        mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
        mpa  = ((ma ^ mb) == {W{1'b1}});
    endtask

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
        int cyc;
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
        busy_cnt = 0; cyc = 0; timed_out = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            timed_out = 1;
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] es, input logic eco,
                              input logic eov, input logic epa);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(eco));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eov));
        chk({tag, "_prop_all"}, 64'(prop_all), 64'(epa));
    endtask

    vec_t vt[4];

    initial begin
        logic [W-1:0] es, sa, sb;
        logic eco, eov, epa;
        int dcount;
        logic [W-1:0] seen;

        vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h12345678, 32'h0FEDCBA9, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0};

        // Reset state
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_sum", 64'(sum), 0);
        chk("rst_flags", 64'({cout, ovf, prop_all}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_cnt), 64'(NIB));
            chk($sformatf("vec%0d_busy_at_done", i), 64'(busy), 0);
            chk_result($sformatf("vec%0d", i), vt[i].s, vt[i].co, vt[i].ov, vt[i].pa);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 0);
            chk($sformatf("vec%0d_hold_sum", i), 64'(sum), 64'(vt[i].s));
        end

        // Random operands against the model, including forced edge patterns
        for (int i = 0; i < 40; i++) begin
            sa = $urandom; sb = $urandom;
            if (i % 8 == 0) sb = ~sa;
            if (i % 8 == 1) begin sa = 32'h80000000; sb = 32'h80000000 | (32'($urandom) & 32'h1); end
            model(sa, sb, 1'(i), es, eco, eov, epa);
            run_op(sa, sb, 1'(i));
            chk_result($sformatf("rnd%0d", i), es, eco, eov, epa);
        end

        // Start while busy must be ignored; only one done pulse
        @(negedge clk);
        start = 1'b1; a = 32'h00001111; b = 32'h00002222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 32'hAAAA0000; b = 32'h05550000; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0; seen = '0;
        for (int c = 0; c < 25; c++) begin
            if (done) begin dcount++; seen = sum; end
            @(negedge clk);
        end
        chk("ignore_done_count", 64'(dcount), 1);
        chk("ignore_sum", 64'(seen), 64'h00003333);

        // Back-to-back: start issued in the done cycle, no bubble
        run_op(32'h00000010, 32'h00000020, 1'b0);
        chk_result("b2b_first", 32'h30, 1'b0, 1'b0, 1'b0);
        run_op(32'h00000001, 32'h00000002, 1'b0);
        chk("b2b_busy_cycles", 64'(busy_cnt), 64'(NIB));
        chk_result("b2b_second", 32'h3, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1; a = 32'h11111111; b = 32'h22222222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_done", 64'(done), 0);
        chk("midrst_sum", 64'(sum), 0);
        chk("midrst_flags", 64'({cout, ovf, prop_all}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 15; c++) begin
            if (done || busy) dcount++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(dcount), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
